// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode constants and
// constant helper functions used when sizing pointers and checking parameters.
package fifo_pkg;

    // Read-mode selectors for the FWFT parameter
    localparam int FWFT_OFF = 0;   // registered read: data one cycle after rd_en
    localparam int FWFT_ON  = 1;   // head word always visible, rd_en pops

    // Ceiling log2. Returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // True when value is a positive power of two.
    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle of the synchronous FIFO.
// master = the agent that pushes and pops, slave = the FIFO itself.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int AW = clog2(DEPTH);

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              clr_err;

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [AW:0]       level;
    logic [AW:0]       free;
    logic              overflow;
    logic              underflow;

    modport master (
        output wr_en, wr_data, rd_en, clr_err,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, free, overflow, underflow
    );

    modport slave (
        input  wr_en, wr_data, rd_en, clr_err,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               level, free, overflow, underflow
    );

endinterface

// File: rtl/fifo_ram_dp.sv
// Storage array of the FIFO: one synchronous write port, one asynchronous
// read port. Contents are deliberately not reset.
module fifo_ram_dp
    import fifo_pkg::*;
#(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 8,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word on the rising edge when enabled
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO built on a circular buffer.
// Occupancy is tracked by a level register; all flags decode from it so they
// follow reset immediately. FWFT selects registered or fall-through reads.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FWFT_OFF
) (
    input  logic                clk,
    input  logic                rst_n,
    param_sync_fifo_if.slave    bus
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);
    localparam logic [LW-1:0] AF_THRESH = LW'(AF_LEVEL);
    localparam logic [LW-1:0] AE_THRESH = LW'(AE_LEVEL);

    // Reject parameter sets the logic below cannot honour
    if (DATA_W < 1) begin : g_err_data_w
        $error("param_sync_fifo: DATA_W must be at least 1");
    end
    if (DEPTH < 2 || !is_pow2(DEPTH)) begin : g_err_depth
        $error("param_sync_fifo: DEPTH must be a power of two and at least 2");
    end
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_err_af
        $error("param_sync_fifo: AF_LEVEL must lie in 1..DEPTH");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_err_ae
        $error("param_sync_fifo: AE_LEVEL must lie in 0..DEPTH-1");
    end
    if (FWFT != FWFT_OFF && FWFT != FWFT_ON) begin : g_err_fwft
        $error("param_sync_fifo: FWFT must be 0 or 1");
    end

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level;
    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_rej;
    logic              rd_rej;
    logic [DATA_W-1:0] head;

    assign full  = (level == LEVEL_MAX);
    assign empty = (level == '0);

    // A read needs data present; a write may use the slot a same-cycle read frees.
    // No bypass: a write into an empty FIFO is not readable in the same cycle.
    assign rd_acc = bus.rd_en && !empty;
    assign wr_acc = bus.wr_en && (!full || rd_acc);
    assign wr_rej = bus.wr_en && !wr_acc;
    assign rd_rej = bus.rd_en && !rd_acc;

    fifo_ram_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we     (wr_acc),
        .waddr  (wr_ptr),
        .wdata  (bus.wr_data),
        .raddr  (rd_ptr),
        .rdata  (head)
    );

    // Pointers advance only on accepted operations and wrap naturally at DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Occupancy: up on push only, down on pop only, hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else begin
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky error flags; a new error wins over a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (wr_rej) begin
                bus.overflow <= 1'b1;
            end else if (bus.clr_err) begin
                bus.overflow <= 1'b0;
            end
            if (rd_rej) begin
                bus.underflow <= 1'b1;
            end else if (bus.clr_err) begin
                bus.underflow <= 1'b0;
            end
        end
    end

    assign bus.level        = level;
    assign bus.free         = LEVEL_MAX - level;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (level >= AF_THRESH);
    assign bus.almost_empty = (level <= AE_THRESH);

    if (FWFT == FWFT_ON) begin : g_fwft
        // Head word is shown straight from storage; forced to zero while empty
        // so the output does not expose stale or unreset array contents.
        assign bus.rd_data  = empty ? '0 : head;
        assign bus.rd_valid = !empty;
    end else begin : g_reg_read
        logic [DATA_W-1:0] rd_data_q;
        logic              rd_valid_q;

        // Registered read: capture the head on an accepted pop, flag it for one cycle
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= head;
                end
            end
        end

        assign bus.rd_data  = rd_data_q;
        assign bus.rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: a registered-read and a fall-through instance
// (DEPTH=4, DATA_W=16) receive identical stimulus and are compared each cycle
// against a queue-based reference model.
module tb_param_sync_fifo;
    import fifo_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int AF    = DEPTH - 1;
    localparam int AE    = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_reg ();
    param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus_fw ();

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(FWFT_OFF)) dut_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_reg)
    );

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .FWFT(FWFT_ON)) dut_fw (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_fw)
    );

    // Reference model state
    logic [DW-1:0] q [$];
    logic [DW-1:0] exp_rd_data;
    logic          exp_rd_valid;
    logic          exp_ovf;
    logic          exp_udf;

    int    n_chk = 0;
    int    n_err = 0;
    string phase = "reset";

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: got %0h expected %0h at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_rd_data  = '0;
        exp_rd_valid = 1'b0;
        exp_ovf      = 1'b0;
        exp_udf      = 1'b0;
    endtask

    task automatic model_clock(input logic wr, input logic [DW-1:0] wd,
                               input logic rd, input logic clr);
        int n;
        bit rd_ok;
        bit wr_ok;
        n     = q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd_ok);
        exp_rd_valid = rd_ok;
        if (rd_ok) begin
            exp_rd_data = q.pop_front();
        end
        if (wr_ok) begin
            q.push_back(wd);
        end
        if (wr && !wr_ok)      exp_ovf = 1'b1;
        else if (clr)          exp_ovf = 1'b0;
        if (rd && !rd_ok)      exp_udf = 1'b1;
        else if (clr)          exp_udf = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("reg_level", 32'(bus_reg.level), 32'(n));
        chk("reg_free",  32'(bus_reg.free),  32'(DEPTH - n));
        chk("reg_full",  32'(bus_reg.full),  32'(n == DEPTH));
        chk("reg_empty", 32'(bus_reg.empty), 32'(n == 0));
        chk("reg_af",    32'(bus_reg.almost_full),  32'(n >= AF));
        chk("reg_ae",    32'(bus_reg.almost_empty), 32'(n <= AE));
        chk("reg_ovf",   32'(bus_reg.overflow),  32'(exp_ovf));
        chk("reg_udf",   32'(bus_reg.underflow), 32'(exp_udf));
        chk("reg_valid", 32'(bus_reg.rd_valid),  32'(exp_rd_valid));
        chk("reg_data",  32'(bus_reg.rd_data),   32'(exp_rd_data));
        chk("fw_level",  32'(bus_fw.level), 32'(n));
        chk("fw_free",   32'(bus_fw.free),  32'(DEPTH - n));
        chk("fw_full",   32'(bus_fw.full),  32'(n == DEPTH));
        chk("fw_empty",  32'(bus_fw.empty), 32'(n == 0));
        chk("fw_ovf",    32'(bus_fw.overflow),  32'(exp_ovf));
        chk("fw_udf",    32'(bus_fw.underflow), 32'(exp_udf));
        chk("fw_valid",  32'(bus_fw.rd_valid),  32'(n > 0));
        chk("fw_data",   32'(bus_fw.rd_data),   (n > 0) ? 32'(q[0]) : 32'h0);
    endtask

    task automatic drive(input logic wr, input logic [DW-1:0] wd,
                         input logic rd, input logic clr);
        bus_reg.wr_en   = wr;  bus_fw.wr_en   = wr;
        bus_reg.wr_data = wd;  bus_fw.wr_data = wd;
        bus_reg.rd_en   = rd;  bus_fw.rd_en   = rd;
        bus_reg.clr_err = clr; bus_fw.clr_err = clr;
    endtask

    // One clock of stimulus; outputs checked on the following falling edge
    task automatic step(input logic wr, input logic [DW-1:0] wd,
                        input logic rd, input logic clr);
        drive(wr, wd, rd, clr);
        @(posedge clk);
        model_clock(wr, wd, rd, clr);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Fill to full, then one write too many
        phase = "fill";
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 0);
        step(1, 16'h4444, 0, 0);
        chk("full_after4", 32'(bus_reg.full), 32'h1);
        chk("level_after4", 32'(bus_reg.level), 32'd4);
        chk("free_after4", 32'(bus_reg.free), 32'd0);
        step(1, 16'h5555, 0, 0);
        chk("ovf_5th", 32'(bus_reg.overflow), 32'h1);
        chk("level_5th", 32'(bus_reg.level), 32'd4);

        // Drain in order
        phase = "drain";
        for (int i = 1; i <= 4; i++) begin
            step(0, '0, 1, 0);
            chk("drain_data", 32'(bus_reg.rd_data), 32'(16'h1111 * i));
            chk("drain_valid", 32'(bus_reg.rd_valid), 32'h1);
        end
        chk("drain_empty", 32'(bus_reg.empty), 32'h1);
        step(0, '0, 0, 1);

        // Full with simultaneous read and write
        phase = "full_rw";
        step(1, 16'h1111, 0, 0);
        step(1, 16'h2222, 0, 0);
        step(1, 16'h3333, 0, 0);
        step(1, 16'h4444, 0, 0);
        step(1, 16'h5555, 1, 0);
        chk("rw_data", 32'(bus_reg.rd_data), 32'h1111);
        chk("rw_level", 32'(bus_reg.level), 32'd4);
        chk("rw_ovf", 32'(bus_reg.overflow), 32'h0);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);
        chk("rw_last", 32'(bus_reg.rd_data), 32'h5555);

        // Underflow on empty, data holds, then clear
        phase = "underflow";
        step(0, '0, 1, 0);
        chk("udf_set", 32'(bus_reg.underflow), 32'h1);
        chk("udf_valid", 32'(bus_reg.rd_valid), 32'h0);
        chk("udf_hold", 32'(bus_reg.rd_data), 32'h5555);
        step(0, '0, 0, 1);
        chk("udf_clr", 32'(bus_reg.underflow), 32'h0);

        // Empty with read and write together: write lands, read rejected
        phase = "empty_rw";
        step(1, 16'h0A0A, 1, 0);
        chk("erw_udf", 32'(bus_reg.underflow), 32'h1);
        chk("erw_level", 32'(bus_reg.level), 32'd1);
        step(0, '0, 1, 1);
        chk("erw_data", 32'(bus_reg.rd_data), 32'h0A0A);
        chk("erw_udf_clr", 32'(bus_reg.underflow), 32'h0);

        // Interleaved write/read pairs wrap the pointers twice
        phase = "interleave";
        for (int i = 1; i <= 10; i++) begin
            step(1, 16'(i), 0, 0);
            step(0, '0, 1, 0);
            chk("il_data", 32'(bus_reg.rd_data), 32'(i));
        end
        chk("il_ovf", 32'(bus_reg.overflow), 32'h0);
        chk("il_udf", 32'(bus_reg.underflow), 32'h0);

        // Fall-through: head visible without rd_en, pop empties
        phase = "fwft";
        step(1, 16'hABCD, 0, 0);
        chk("fw_valid1", 32'(bus_fw.rd_valid), 32'h1);
        chk("fw_data1", 32'(bus_fw.rd_data), 32'hABCD);
        step(0, '0, 1, 0);
        chk("fw_empty1", 32'(bus_fw.empty), 32'h1);

        // Asynchronous reset with three entries stored
        phase = "mid_reset";
        step(1, 16'h0101, 0, 0);
        step(1, 16'h0202, 0, 0);
        step(1, 16'h0303, 1, 0);
        step(1, 16'h0404, 0, 0);
        step(0, '0, 0, 0);
        chk("pre_level", 32'(bus_reg.level), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("rst_level", 32'(bus_reg.level), 32'd0);
        chk("rst_free", 32'(bus_reg.free), 32'd4);
        chk("rst_data", 32'(bus_reg.rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 16'h00FF, 0, 0);
        step(0, '0, 1, 0);
        chk("post_rst_data", 32'(bus_reg.rd_data), 32'h00FF);

        // Randomised traffic against the model
        phase = "random";
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) < 55, 16'($urandom),
                 $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 10);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
